// File: rtl/ca_pkg.sv
// Shared definitions for the carry-less sequential divider: default factor
// width and the controller state encoding.
package ca_pkg;

    localparam int M_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ca_msb_find.sv
// Priority encoder: index of the most significant set bit of value, with a
// flag raised when value is all zeros.
module ca_msb_find #(
    parameter int W = 8
) (
    input  logic [W-1:0]         value,
    output logic [$clog2(W)-1:0] index,
    output logic                 zero
);

    localparam int IW = $clog2(W);

    // Ascending scan, so the highest set bit is the last one written.
    always_comb begin
        index = '0;
        zero  = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                index = IW'(i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ca_div_seq.sv
// Sequential GF(2) polynomial divider: p = q*b ^ r, one shift-XOR reduction
// step per clock through a single reused datapath stage.
module ca_div_seq
    import ca_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*M-2:0] p,
    input  logic [M-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [M-1:0]   q,
    output logic [M-2:0]   r,
    output logic           err,
    output logic           ovf
);

    localparam int PW = 2 * M - 1;
    localparam int KW = $clog2(2 * M);
    localparam int DW = $clog2(M);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   w_reg;
    logic [M-1:0]    b_reg;
    logic [PW-1:0]   q_acc;
    logic [KW-1:0]   k_reg;
    logic [DW-1:0]   d_reg;
    logic            err_reg;

    logic [DW-1:0]   msb_idx;
    logic            b_zero;
    logic            accept;
    logic [KW-1:0]   d_ext;
    logic [KW-1:0]   shamt;
    logic            k_real;
    logic            step;
    logic [PW-1:0]   b_shifted;

    ca_msb_find #(.W(M)) u_msb (
        .value (b_reg),
        .index (msb_idx),
        .zero  (b_zero)
    );

    assign accept    = start && (state == IDLE || state == DONE);
    assign d_ext     = KW'(d_reg);
    assign shamt     = k_reg - d_ext;
    assign b_shifted = {{(PW - M){1'b0}}, b_reg} << shamt;

    // k = 2M-1 marks an empty leading DIV cycle that makes the nonzero-divisor
    // latency 2M+2; the real reduction steps run k = 2M-2 down to 0.
    assign k_real = (k_reg != KW'(PW));
    assign step   = (state == DIV) && k_real && w_reg[k_reg] && (k_reg >= d_ext);

    always_comb begin
        state_next = state;
        busy       = (state == NORM) || (state == DIV);
        case (state)
            IDLE: if (start) state_next = NORM;
            NORM: state_next = b_zero ? DONE : DIV;
            DIV:  if (k_reg == '0) state_next = DONE;
            DONE: state_next = start ? NORM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            w_reg   <= '0;
            b_reg   <= '0;
            q_acc   <= '0;
            k_reg   <= '0;
            d_reg   <= '0;
            err_reg <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            r       <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                NORM: begin
                    err_reg <= b_zero;
                    d_reg   <= msb_idx;
                    k_reg   <= KW'(PW);
                end
                DIV: begin
                    if (step) begin
                        w_reg <= w_reg ^ b_shifted;
                        q_acc <= q_acc | (PW'(1) << shamt);
                    end
                    k_reg <= k_reg - 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    err  <= err_reg;
                    if (err_reg) begin
                        q   <= '0;
                        r   <= '0;
                        ovf <= 1'b0;
                    end else begin
                        q   <= q_acc[M-1:0];
                        r   <= w_reg[M-2:0];
                        ovf <= |q_acc[PW-1:M];
                    end
                end
                default: ;
            endcase
            if (accept) begin
                w_reg   <= p;
                b_reg   <= b;
                q_acc   <= '0;
                err_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ca_div_seq.sv
// Scoreboard bench for ca_div_seq (M=8): directed divisions, latency,
// handshake, back-to-back and reset-abort behaviour.
module tb_ca_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] p;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  q;
    logic [6:0]  r;
    logic        err;
    logic        ovf;

    typedef struct {
        logic [7:0] q;
        logic [6:0] r;
        logic       err;
        logic       ovf;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ca_div_seq #(.M(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .p     (p),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .err   (err),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("q", 32'(q), 32'(mon_e.q));
                checkOutput("r", 32'(r), 32'(mon_e.r));
                checkOutput("err", 32'(err), 32'(mon_e.err));
                checkOutput("ovf", 32'(ovf), 32'(mon_e.ovf));
                checkOutput("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    // Called at a negedge; drives start now, then waits until the operation
    // has left the busy states (and optionally past its done pulse).
    task automatic applyStimulus(input logic [14:0] pv, input logic [7:0] bv,
                                 input logic [7:0] eq, input logic [6:0] er,
                                 input logic ee, input logic eo, input int elat,
                                 input bit wait_done);
        exp_t e;
        int   n;
        start = 1'b1;
        p     = pv;
        b     = bv;
        e.q = eq; e.r = er; e.err = ee; e.ovf = eo; e.lat = elat; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) checkOutput("busy_timeout", 32'd1, 32'd0);
        if (wait_done) begin
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        p     = 15'h0005;
        b     = 8'h03;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_r", 32'(r), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        applyStimulus(15'h0005, 8'h03, 8'h03, 7'h00, 1'b0, 1'b0, 18, 1'b1);
        applyStimulus(15'h0007, 8'h03, 8'h02, 7'h01, 1'b0, 1'b0, 18, 1'b1);
        applyStimulus(15'h5555, 8'hFF, 8'hFF, 7'h00, 1'b0, 1'b0, 18, 1'b1);
        applyStimulus(15'h1234, 8'h00, 8'h00, 7'h00, 1'b1, 1'b0, 2, 1'b1);
        applyStimulus(15'h4000, 8'h01, 8'h00, 7'h00, 1'b0, 1'b1, 18, 1'b1);
        applyStimulus(15'h00FF, 8'h80, 8'h01, 7'h7F, 1'b0, 1'b0, 18, 1'b1);
        applyStimulus(15'h0001, 8'h02, 8'h00, 7'h01, 1'b0, 1'b0, 18, 1'b1);

        // Back-to-back: second start lands in the DONE cycle of the first.
        applyStimulus(15'h0007, 8'h03, 8'h02, 7'h01, 1'b0, 1'b0, 18, 1'b0);
        applyStimulus(15'h1234, 8'h00, 8'h00, 7'h00, 1'b1, 1'b0, 2, 1'b0);
        applyStimulus(15'h0005, 8'h03, 8'h03, 7'h00, 1'b0, 1'b0, 18, 1'b1);

        // Starts pulsed while busy must be ignored.
        begin
            exp_t e;
            int   n;
            start = 1'b1; p = 15'h0007; b = 8'h03;
            e.q = 8'h02; e.r = 7'h01; e.err = 1'b0; e.ovf = 1'b0; e.lat = 18; e.acc = cyc + 1;
            sb.push_back(e);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                start = (n == 5 || n == 10);
                p     = 15'h4000;
                b     = 8'h00;
                if (n == 3) checkOutput("hold_q", 32'(q), 32'h03);
            end while ((busy || n < 2) && n < 60);
            start = 1'b0;
            if (n >= 60) checkOutput("busy_timeout", 32'd1, 32'd0);
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of DIV aborts without a done pulse.
        start = 1'b1; p = 15'h5555; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_q", 32'(q), 32'd0);
        checkOutput("abort_r", 32'(r), 32'd0);
        repeat (25) @(negedge clk);

        applyStimulus(15'h0005, 8'h03, 8'h03, 7'h00, 1'b0, 1'b0, 18, 1'b1);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
